// File: rtl/dot_accumulator_pkg.sv
// Shared types and constants for the dot-product accumulator and its multiply stage.
package dot_accumulator_pkg;

  // Operand width agreed with the external multiply stage.
  localparam int unsigned MulWidth = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } dot_state_e;

endpackage

// File: rtl/dot_accumulator.sv
// Dot-product sequencer: feeds operand pairs to an external multiplier from registers
// and sums the returned products into a wrap-around accumulator.
module dot_accumulator
  import dot_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH = MulWidth,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] mul_x1,
  output logic [WIDTH-1:0] mul_x2,
  input  logic [WIDTH-1:0] mul_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [LEN_W-1:0] out_count
);

  dot_state_e       state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] remaining_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] x1_q;
  logic [WIDTH-1:0] x2_q;
  logic             pend_q;
  logic             accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      remaining_q <= '0;
      acc_q       <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      pend_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            len_q       <= cmd_len;
            remaining_q <= cmd_len;
            acc_q       <= '0;
            pend_q      <= 1'b0;
            state_q     <= (cmd_len != '0) ? StRun : StDone;
          end
        end
        StRun: begin
          // pend_q marks that mul_f reflects a pair registered on the previous edge.
          if (pend_q) begin
            acc_q <= acc_q + mul_f;
          end
          pend_q <= accept;
          if (accept) begin
            x1_q        <= in_a;
            x2_q        <= in_b;
            remaining_q <= remaining_q - 1'b1;
          end
          if (remaining_q == '0 && !pend_q) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign in_ready  = (state_q == StRun) && (remaining_q != '0);
  assign out_valid = (state_q == StDone);
  assign out_sum   = acc_q;
  assign out_count = len_q;
  assign mul_x1    = x1_q;
  assign mul_x2    = x2_q;

endmodule

// File: tb/tb_dot_accumulator.sv
// Self-checking bench for dot_accumulator with a behavioural multiplier beside it.
module tb_dot_accumulator;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] mul_x1;
  logic [WIDTH-1:0] mul_x2;
  logic [WIDTH-1:0] mul_f;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [LEN_W-1:0] out_count;

  logic [WIDTH-1:0] va[16];
  logic [WIDTH-1:0] vb[16];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Stand-in for the external combinational multiply stage (lower product bits).
  assign mul_f = mul_x1 * mul_x2;

  dot_accumulator #(
    .WIDTH(WIDTH),
    .LEN_W(LEN_W)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_len  (cmd_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .mul_x1   (mul_x1),
    .mul_x2   (mul_x2),
    .mul_f    (mul_f),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: full-precision products summed, then reduced mod 2^32.
  function automatic logic [31:0] ref_dot(input int len);
    logic [63:0] total;
    logic [63:0] p;
    total = 64'd0;
    for (int i = 0; i < len; i++) begin
      p     = 64'(va[i]) * 64'(vb[i]);
      total = total + p;
    end
    return total[31:0];
  endfunction

  task automatic do_cmd(input int len, input int gap, input int hold, input bit noise);
    logic [31:0] exp_sum;
    int w;
    exp_sum = ref_dot(len);
    w = 0;
    while (!cmd_ready && w < 50) begin
      tick();
      w++;
    end
    check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_len   = 8'(len);
    tick();
    cmd_valid = 1'b0;
    cmd_len   = 8'($urandom);
    check_eq("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    if (len == 0) begin
      check_eq("zero_in_ready", 32'(in_ready), 32'd0);
      check_eq("zero_latency", 32'(out_valid), 32'd1);
    end else begin
      for (int i = 0; i < len; i++) begin
        if (i > 0) begin
          for (int g = 0; g < gap; g++) begin
            in_a = $urandom;
            in_b = $urandom;
            tick();
          end
        end
        check_eq("in_ready_run", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = va[i];
        in_b     = vb[i];
        tick();
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
      end
      check_eq("lat_t0", 32'(out_valid), 32'd0);
      tick();
      check_eq("lat_t1", 32'(out_valid), 32'd0);
      tick();
      check_eq("lat_t2", 32'(out_valid), 32'd1);
      check_eq("mul_x1_hold", mul_x1, va[len-1]);
      check_eq("mul_x2_hold", mul_x2, vb[len-1]);
    end
    check_eq("out_sum", out_sum, exp_sum);
    check_eq("out_count", 32'(out_count), 32'(len));
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (noise) begin
        in_valid  = 1'b1;
        in_a      = $urandom;
        in_b      = $urandom;
        cmd_valid = 1'b1;
        cmd_len   = 8'($urandom_range(1, 9));
      end
      tick();
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_sum", out_sum, exp_sum);
      check_eq("hold_count", 32'(out_count), 32'(len));
      check_eq("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("post_valid", 32'(out_valid), 32'd0);
    check_eq("post_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_mul_x1", mul_x1, 32'd0);
    check_eq("rst_mul_x2", mul_x2, 32'd0);
    check_eq("rst_sum", out_sum, 32'd0);
    check_eq("rst_count", 32'(out_count), 32'd0);

    // Stray operands while idle must be ignored.
    in_valid = 1'b1;
    in_a     = 32'd99;
    in_b     = 32'd99;
    tick();
    in_valid = 1'b0;
    check_eq("idle_in_ready", 32'(in_ready), 32'd0);

    // Basic dot product.
    va[0] = 2; vb[0] = 3; va[1] = 4; vb[1] = 5; va[2] = 6; vb[2] = 7;
    do_cmd(3, 0, 0, 1'b0);

    // Zero length.
    do_cmd(0, 0, 2, 1'b0);

    // Wrap-around.
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF;
    va[1] = 32'h8000_0000; vb[1] = 32'd2;
    do_cmd(2, 0, 1, 1'b0);

    // Input gaps and held result.
    for (int i = 0; i < 4; i++) begin
      va[i] = 32'(i + 1);
      vb[i] = 32'(i + 1);
    end
    do_cmd(4, 2, 5, 1'b1);

    // Reset mid-command discards the partial sum.
    cmd_valid = 1'b1;
    cmd_len   = 8'd5;
    tick();
    cmd_valid = 1'b0;
    in_valid  = 1'b1;
    in_a      = 32'd11;
    in_b      = 32'd13;
    tick();
    in_a = 32'd17;
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
    va[0] = 7; vb[0] = 9;
    do_cmd(1, 0, 0, 1'b0);

    // Back-to-back commands.
    va[0] = 3; vb[0] = 3;
    do_cmd(1, 0, 0, 1'b0);
    va[0] = 5; vb[0] = 5;
    do_cmd(1, 0, 0, 1'b0);

    // Randomized commands.
    for (int k = 0; k < 25; k++) begin
      int len;
      len = int'($urandom_range(0, 8));
      for (int i = 0; i < len; i++) begin
        va[i] = $urandom;
        vb[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      do_cmd(len, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
